// File: rtl/tape_unit.sv
// tape_unit: Turing-machine tape made of DEPTH cells of SYMW-bit symbols, with
// an integrated head counter and a valid/ready step interface.
// After reset the unit blank-fills every cell, then accepts one
// write+move command at a time. A side port lets the host preload cells.
// Optional feature macro: TAPE_STEP_COUNT_EN adds a saturating step_count output.
module tape_unit #(
    parameter int SYMW  = 2,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int HOME  = 0,
    parameter int BLANK = 0,
    parameter int WRAP  = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [SYMW-1:0] cmd_sym,
    input  logic [1:0]      cmd_move,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [SYMW-1:0] load_data,
    output logic [SYMW-1:0] rd_sym,
    output logic            rd_valid,
    output logic [AW-1:0]   head_pos,
`ifdef TAPE_STEP_COUNT_EN
    output logic [31:0]     step_count,
`endif
    output logic            fault,
    input  logic            fault_clr
);

    localparam logic [AW-1:0]   HOME_POS  = AW'(HOME);
    localparam logic [AW-1:0]   LAST_POS  = AW'(DEPTH - 1);
    localparam logic [AW:0]     DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [SYMW-1:0] BLANK_SYM = SYMW'(BLANK);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_IDLE = 2'd1,
        S_EXEC = 2'd2,
        S_READ = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   fill_ptr_q, fill_ptr_d;
    logic [AW-1:0]   head_q, head_d;
    logic [SYMW-1:0] rd_sym_q, rd_sym_d;
    logic            rd_valid_q, rd_valid_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            fault_q, fault_d;
    logic            cmd_write_q, cmd_write_d;
    logic [SYMW-1:0] cmd_sym_q, cmd_sym_d;
    logic [1:0]      cmd_move_q, cmd_move_d;

    logic            fault_set_s;
    logic            mem_we_s;
    logic [AW-1:0]   mem_waddr_s;
    logic [SYMW-1:0] mem_wdata_s;
    logic [AW-1:0]   head_next_s;
    logic            edge_hit_s;

    logic [SYMW-1:0] mem_q [DEPTH];

    // Head movement for the captured command, including edge saturation or wrap.
    always_comb begin
        head_next_s = head_q;
        edge_hit_s  = 1'b0;
        case (cmd_move_q)
            2'b01: begin
                if (head_q == '0) begin
                    if (WRAP != 0) begin
                        head_next_s = LAST_POS;
                    end else begin
                        edge_hit_s = 1'b1;
                    end
                end else begin
                    head_next_s = head_q - AW'(1);
                end
            end
            2'b10: begin
                if (head_q == LAST_POS) begin
                    if (WRAP != 0) begin
                        head_next_s = '0;
                    end else begin
                        edge_hit_s = 1'b1;
                    end
                end else begin
                    head_next_s = head_q + AW'(1);
                end
            end
            default: begin
                head_next_s = head_q;
            end
        endcase
    end

    // Next-state, memory write port and output register next values.
    always_comb begin
        state_d     = state_q;
        fill_ptr_d  = fill_ptr_q;
        head_d      = head_q;
        rd_sym_d    = rd_sym_q;
        rd_valid_d  = 1'b0;
        cmd_write_d = cmd_write_q;
        cmd_sym_d   = cmd_sym_q;
        cmd_move_d  = cmd_move_q;
        fault_set_s = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = head_q;
        mem_wdata_s = cmd_sym_q;
        case (state_q)
            S_FILL: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = fill_ptr_q;
                mem_wdata_s = BLANK_SYM;
                if (fill_ptr_q == LAST_POS) begin
                    fill_ptr_d = '0;
                    rd_sym_d   = BLANK_SYM;
                    state_d    = S_READ;
                end else begin
                    fill_ptr_d = fill_ptr_q + AW'(1);
                end
            end
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    // A command in the same cycle as a load wins; the load is dropped.
                    cmd_write_d = cmd_write;
                    cmd_sym_d   = cmd_sym;
                    cmd_move_d  = cmd_move;
                    state_d     = S_EXEC;
                end else if (load_en) begin
                    if ({1'b0, load_addr} < DEPTH_EXT) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = load_addr;
                        mem_wdata_s = load_data;
                        if (load_addr == head_q) begin
                            rd_sym_d = load_data;
                        end else begin
                            rd_sym_d = rd_sym_q;
                        end
                    end else begin
                        fault_set_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                mem_we_s    = cmd_write_q;
                mem_waddr_s = head_q;
                mem_wdata_s = cmd_sym_q;
                head_d      = head_next_s;
                fault_set_s = edge_hit_s;
                // Symbol under the new head, bypassing the write landing this edge.
                if (cmd_write_q && (head_next_s == head_q)) begin
                    rd_sym_d = cmd_sym_q;
                end else begin
                    rd_sym_d = mem_q[head_next_s];
                end
                rd_valid_d = 1'b1;
                state_d    = S_READ;
            end
            S_READ: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        if (fault_set_s) begin
            fault_d = 1'b1;
        end else if (fault_clr) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end

        cmd_ready_d = (state_d == S_IDLE) && !fault_d;
    end

    // Control and output registers with asynchronous reset into blank-fill.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_FILL;
            fill_ptr_q  <= '0;
            head_q      <= HOME_POS;
            rd_sym_q    <= BLANK_SYM;
            rd_valid_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            fault_q     <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_sym_q   <= '0;
            cmd_move_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            fill_ptr_q  <= fill_ptr_d;
            head_q      <= head_d;
            rd_sym_q    <= rd_sym_d;
            rd_valid_q  <= rd_valid_d;
            cmd_ready_q <= cmd_ready_d;
            fault_q     <= fault_d;
            cmd_write_q <= cmd_write_d;
            cmd_sym_q   <= cmd_sym_d;
            cmd_move_q  <= cmd_move_d;
        end
    end

    // Tape storage: synchronous single write port, contents restored by blank-fill.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

`ifdef TAPE_STEP_COUNT_EN
    logic [31:0] step_cnt_q, step_cnt_d;

    // Saturating count of executed steps, cleared while blank-filling.
    always_comb begin
        if (state_q == S_FILL) begin
            step_cnt_d = 32'd0;
        end else if ((state_q == S_EXEC) && (step_cnt_q != 32'hFFFF_FFFF)) begin
            step_cnt_d = step_cnt_q + 32'd1;
        end else begin
            step_cnt_d = step_cnt_q;
        end
    end

    // Step counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_cnt_q <= 32'd0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    assign step_count = step_cnt_q;
`endif

    assign cmd_ready = cmd_ready_q;
    assign rd_sym    = rd_sym_q;
    assign rd_valid  = rd_valid_q;
    assign head_pos  = head_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_tape_unit.sv
// Bench for tape_unit: two instances (DEPTH=8 saturating, DEPTH=6 wrapping)
// driven by directed and random steps/loads; a tape model in plain arrays
// predicts every read-back, which a monitor checks from a queue.
module tb_tape_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       [2];
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic       cmd_write [2];
    logic [1:0] cmd_sym   [2];
    logic [1:0] cmd_move  [2];
    logic       load_en   [2];
    logic [2:0] load_addr [2];
    logic [1:0] load_data [2];
    logic [1:0] rd_sym    [2];
    logic       rd_valid  [2];
    logic [2:0] head_pos  [2];
    logic       fault     [2];
    logic       fault_clr [2];
`ifdef TAPE_STEP_COUNT_EN
    logic [31:0] step_count [2];
`endif

    tape_unit #(.SYMW(2), .DEPTH(8), .HOME(0), .BLANK(0), .WRAP(0)) dut0 (
        .clock(clk), .reset(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_write(cmd_write[0]), .cmd_sym(cmd_sym[0]), .cmd_move(cmd_move[0]),
        .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0]),
        .rd_sym(rd_sym[0]), .rd_valid(rd_valid[0]), .head_pos(head_pos[0]),
`ifdef TAPE_STEP_COUNT_EN
        .step_count(step_count[0]),
`endif
        .fault(fault[0]), .fault_clr(fault_clr[0])
    );

    tape_unit #(.SYMW(2), .DEPTH(6), .HOME(0), .BLANK(0), .WRAP(1)) dut1 (
        .clock(clk), .reset(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_write(cmd_write[1]), .cmd_sym(cmd_sym[1]), .cmd_move(cmd_move[1]),
        .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1]),
        .rd_sym(rd_sym[1]), .rd_valid(rd_valid[1]), .head_pos(head_pos[1]),
`ifdef TAPE_STEP_COUNT_EN
        .step_count(step_count[1]),
`endif
        .fault(fault[1]), .fault_clr(fault_clr[1])
    );

    // Reference model: tape contents, head, sticky fault, step count per instance.
    int depth_m [2] = '{8, 6};
    int wrap_m  [2] = '{0, 1};
    int tape_m  [2][8];
    int head_m  [2];
    int fault_m [2];
    int steps_m [2];

    typedef struct {
        int k;
        int sym;
        int head;
        int flt;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d, required %0d", name, k, act, exp);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rd_valid[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_valid_unexpected dut%0d: got a pulse, required none", k);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rd_valid_source", k, k, e.k);
                    chk("rd_sym", k, int'(rd_sym[k]), e.sym);
                    chk("head_pos", k, int'(head_pos[k]), e.head);
                    chk("fault_at_read", k, int'(fault[k]), e.flt);
                    chk("rd_valid_latency", k, cyc, e.cyc);
                end
            end
        end
    end

    task automatic idle_inputs(input int k);
        cmd_valid[k] = 1'b0; cmd_write[k] = 1'b0; cmd_sym[k] = 2'd0; cmd_move[k] = 2'd0;
        load_en[k] = 1'b0; load_addr[k] = 3'd0; load_data[k] = 2'd0; fault_clr[k] = 1'b0;
    endtask

    task automatic reset_dut(input int k);
        int n;
        rst[k] = 1'b1;
        idle_inputs(k);
        @(negedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", k, int'(cmd_ready[k]), 0);
        chk("reset_rd_valid", k, int'(rd_valid[k]), 0);
        chk("reset_head_pos", k, int'(head_pos[k]), 0);
        chk("reset_fault", k, int'(fault[k]), 0);
        chk("reset_rd_sym", k, int'(rd_sym[k]), 0);
        rst[k] = 1'b0;
        for (int i = 0; i < 8; i++) tape_m[k][i] = 0;
        head_m[k] = 0; fault_m[k] = 0; steps_m[k] = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cmd_ready[k] !== 1'b1 && n < 100);
        chk("ready_rise_cycles", k, n, depth_m[k] + 1);
    endtask

    task automatic clear_fault(input int k);
        chk("ready_low_in_fault", k, int'(cmd_ready[k]), 0);
        fault_clr[k] = 1'b1;
        @(negedge clk);
        fault_clr[k] = 1'b0;
        fault_m[k] = 0;
        chk("fault_cleared", k, int'(fault[k]), 0);
        chk("ready_after_clr", k, int'(cmd_ready[k]), 1);
    endtask

    task automatic load(input int k, input int a, input int d);
        load_en[k] = 1'b1; load_addr[k] = 3'(a); load_data[k] = 2'(d);
        @(negedge clk);
        load_en[k] = 1'b0;
        if (a < depth_m[k]) tape_m[k][a] = d;
        else fault_m[k] = 1;
        chk("rd_sym_idle", k, int'(rd_sym[k]), tape_m[k][head_m[k]]);
        chk("fault_after_load", k, int'(fault[k]), fault_m[k]);
    endtask

    task automatic step(input int k, input int w, input int s, input int m,
                        input int with_load = 0, input int la = 0, input int ld = 0);
        int n;
        if (fault_m[k] != 0) clear_fault(k);
        n = 0;
        while (cmd_ready[k] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            total++;
            bad++;
            $display("FAIL ready_timeout dut%0d: got cmd_ready low for %0d cycles, required high", k, n);
            return;
        end
        cmd_valid[k] = 1'b1; cmd_write[k] = (w != 0); cmd_sym[k] = 2'(s); cmd_move[k] = 2'(m);
        if (with_load != 0) begin
            load_en[k] = 1'b1; load_addr[k] = 3'(la); load_data[k] = 2'(ld);
        end
        // Model: write at the old head, then move; edges saturate or wrap.
        if (w != 0) tape_m[k][head_m[k]] = s;
        if (m == 1) begin
            if (head_m[k] == 0) begin
                if (wrap_m[k] != 0) head_m[k] = depth_m[k] - 1;
                else fault_m[k] = 1;
            end else head_m[k] = head_m[k] - 1;
        end else if (m == 2) begin
            if (head_m[k] == depth_m[k] - 1) begin
                if (wrap_m[k] != 0) head_m[k] = 0;
                else fault_m[k] = 1;
            end else head_m[k] = head_m[k] + 1;
        end
        steps_m[k]++;
        exp_q.push_back('{k, tape_m[k][head_m[k]], head_m[k], fault_m[k], cyc + 2});
        @(negedge clk);
        cmd_valid[k] = 1'b0;
        load_en[k] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_step", k, int'(cmd_ready[k]), (fault_m[k] != 0) ? 0 : 1);
    endtask

    task automatic random_ops(input int k, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                load(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            end else if ($urandom_range(0, 7) == 0) begin
                step(k, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1, int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 3)));
            end else begin
                step(k, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
            end
        end
    endtask

    task automatic check_steps(input int k);
`ifdef TAPE_STEP_COUNT_EN
        chk("step_count", k, int'(step_count[k]), steps_m[k]);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            idle_inputs(k);
        end
        @(negedge clk);

        // ---- DEPTH=8, saturating edges ----
        reset_dut(0);
        check_steps(0);
        load(0, 0, 1); load(0, 1, 2); load(0, 2, 3);
        step(0, 0, 0, 2); step(0, 0, 0, 2); step(0, 0, 0, 2);   // reads 2,3,0
        step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);   // back to cell 0
        step(0, 1, 3, 1);                                        // left edge overrun
        @(negedge clk);
        @(negedge clk);
        chk("fault_sticky", 0, int'(fault[0]), 1);
        clear_fault(0);
        load(0, 5, 1);
        step(0, 0, 0, 0, 1, 5, 2);                               // load dropped
        for (int i = 0; i < 7; i++) step(0, 0, 0, 2);            // walks over cell 5, hits right edge
        random_ops(0, 40);
        check_steps(0);

        // Reset while the unit is executing a captured command.
        if (fault_m[0] != 0) clear_fault(0);
        n = 0;
        while (cmd_ready[0] !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_sym[0] = 2'd2; cmd_move[0] = 2'd2;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        rst[0] = 1'b1;
        reset_dut(0);
        check_steps(0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 2);            // every cell reads blank

        // ---- DEPTH=6, wrapping edges ----
        reset_dut(1);
        step(1, 1, 3, 1);                                        // wraps to cell 5, no fault
        load(1, 6, 2);                                           // out of range -> fault
        clear_fault(1);
        step(1, 0, 0, 2);                                        // wraps to cell 0, reads 3
        random_ops(1, 40);
        check_steps(1);

        repeat (4) @(negedge clk);
        chk("queue_drained", 0, exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
